multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multicycle MIPS-style datapath. Steps each instruction
// through FETCH / DECODE and an opcode-specific execution path, driving the
// datapath write enables and mux selects from the current state.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset (forces FETCH at once)
//   opcode     in   6  instr[31:26] from the instruction register
//   zero       in   1  ALU zero flag (qualifies pcen in BEQ)
//   mem_ready  in   1  memory access completes this cycle
//   iord       out  1  memory address source: 0 = PC, 1 = ALUOut
//   irwrite    out  1  instruction register write enable
//   memwrite   out  1  memory write enable
//   regwrite   out  1  register file write enable
//   regdst     out  1  register file write-address select
//   memtoreg   out  1  register file write-data select
//   alusrca    out  1  ALU A select: 0 = PC, 1 = reg A
//   alusrcb    out  2  ALU B select: 00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   aluop      out  2  00 add, 01 sub, 10 use funct
//   pcsrc      out  2  00 ALUResult, 01 ALUOut, 10 jump target
//   pcen       out  1  PC load enable
//   illegal    out  1  one-cycle pulse in DECODE for an unrecognised opcode
//   state      out  4  current state, for debug
//
// Configuration macro:
//   MULTICYCLE_MEM_STALL_EN  defined   -> FETCH, MEMRD and MEMWR wait on mem_ready
//                            undefined -> mem_ready is ignored (treated as 1)
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic       ready_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       pcen_s;
    logic       illegal_s;

`ifdef MULTICYCLE_MEM_STALL_EN
    assign ready_s = mem_ready;
`else
    // Memory is assumed single-cycle; the port is kept for pin compatibility.
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready;
    assign ready_s = 1'b1;
`endif

    // Decode target for the DECODE state; unknown opcodes fall back to FETCH.
    function automatic logic [3:0] decode_target(input logic [5:0] op);
        logic [3:0] tgt;
        case (op)
            OP_LW, OP_SW: tgt = S_MEMADR;
            OP_RTYPE:     tgt = S_EXEC;
            OP_BEQ:       tgt = S_BEQ;
            OP_ADDI:      tgt = S_ADDIEX;
            OP_J:         tgt = S_JUMP;
            default:      tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

    // True when the opcode belongs to the supported instruction set.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register: asynchronous reset returns to FETCH mid-instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_state_s = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: next_state_s = decode_target(opcode);
            S_MEMADR: next_state_s = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state_s = ready_s ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = ready_s ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BEQ:    next_state_s = S_FETCH;
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_ADDIWB: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Output decode: Moore on state, with pcen/irwrite qualified by ready/zero.
    always_comb begin
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        pcen_s     = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = ready_s;
                pcen_s    = ready_s;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb   = 2'b11;
                illegal_s = ~op_is_legal(opcode);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                // Held for the whole stall so the memory sees a stable request.
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen_s  = zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    // While reset is held, state is FETCH but no enable may fire even if
    // mem_ready is high.
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcen     = pcen_s     & ~reset;
    assign illegal  = illegal_s  & ~reset;
    assign state    = state_r;

endmodule
